// File: rtl/spi_word_deser_pkg.sv
// rtl/spi_word_deser_pkg.sv - shared analyzer types for the SPI word deserializer and trigger stage
// Purpose: FSM state encoding, default word width and a saturating counter helper.
// Ports: none (package).
package spi_word_deser_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/spi_word_deser_if.sv
// rtl/spi_word_deser_if.sv - SPI input pins and deserialized word outputs
// Purpose: groups the asynchronous SPI pins and the word-side outputs.
// Ports: spi_sck/spi_cs_n/spi_mosi (SPI side), word/word_valid/start/frame_err/word_cnt (result side).
//   master: drives the SPI pins, observes results. slave: the deserializer.
interface spi_word_deser_if
  import spi_word_deser_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              start;
  logic              frame_err;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    output spi_sck, spi_cs_n, spi_mosi,
    input  word, word_valid, start, frame_err, word_cnt
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi,
    output word, word_valid, start, frame_err, word_cnt
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset level
// Purpose: brings one asynchronous bit into the clk domain.
// Ports: clk, rst_n (sync active-low), d (async in), q (synchronized out).
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_word_deser.sv
// rtl/spi_word_deser.sv - oversampling SPI slave that deserializes fixed-width words
// Purpose: samples SPI_SCK/CS_N/MOSI on sclk, shifts bits on the selected SCK edge,
//   emits completed words with a one-cycle valid, flags frames that end mid-word.
// Ports: sclk (oversampling clock), rst_n (sync active-low),
//   bus (slave modport): spi_sck/spi_cs_n/spi_mosi in; word, word_valid, start,
//   frame_err, word_cnt out.
module spi_word_deser
  import spi_word_deser_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SAMPLE_EDGE = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic              sclk,
  input  logic              rst_n,
  spi_word_deser_if.slave   bus
);

  localparam int                BCNT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
  // SCK rests at the level it leaves on the sampling transition.
  localparam logic              SCK_IDLE = (SAMPLE_EDGE != 0) ? 1'b1 : 1'b0;

  logic cs_s, sck_s, mosi_s;
  logic sck_d, cs_d;
  logic [1:0] settle_cnt;
  logic settled;

  logic sample_edge, cs_fall, cs_rise;

  state_t state_q, state_d;

  logic shift_en, word_done, frame_clear, err_set;
  logic [BCNT_W-1:0] bits_next;

  logic [BCNT_W-1:0] bit_cnt_q;
  logic [WORD_W-1:0] shreg_q, shreg_next;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;
  logic              frame_err_q;
  logic [CNT_W-1:0]  word_cnt_q;

  sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(sclk), .rst_n(rst_n), .d(bus.spi_cs_n), .q(cs_s)
  );

  sync2 #(.RST_VAL(SCK_IDLE)) u_sync_sck (
    .clk(sclk), .rst_n(rst_n), .d(bus.spi_sck), .q(sck_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(sclk), .rst_n(rst_n), .d(bus.spi_mosi), .q(mosi_s)
  );

  assign settled = (settle_cnt == 2'd2);

  // cs_d holds 0 until the synchronizer has flushed its reset value, so a
  // CS_N that was already low across reset never looks like a fresh 1->0.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      sck_d      <= SCK_IDLE;
      cs_d       <= 1'b0;
      settle_cnt <= 2'd0;
    end else begin
      sck_d <= sck_s;
      cs_d  <= settled ? cs_s : 1'b0;
      if (!settled) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
    end
  end

  // The sampling transition is the one that moves SCK away from its idle level.
  assign sample_edge = (sck_s != sck_d) && (sck_s != SCK_IDLE);
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A completing edge in the same cycle as the deassert leaves bits_next at
  // zero, so that frame ends cleanly rather than as an error.
  always_comb begin
    shift_en    = 1'b0;
    word_done   = 1'b0;
    frame_clear = 1'b0;
    err_set     = 1'b0;
    bits_next   = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        frame_clear = cs_fall;
      end
      ST_SHIFT: begin
        shift_en  = sample_edge;
        word_done = sample_edge && (bit_cnt_q == LAST_BIT);
        if (word_done) begin
          bits_next = '0;
        end else if (sample_edge) begin
          bits_next = bit_cnt_q + BCNT_W'(1);
        end
        err_set = cs_rise && (bits_next != '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    shreg_next = shreg_q;
    if (MSB_FIRST != 0) begin
      shreg_next = {shreg_q[WORD_W-2:0], mosi_s};
    end else begin
      shreg_next = {mosi_s, shreg_q[WORD_W-1:1]};
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      word_valid_q <= word_done;
      frame_err_q  <= err_set;
      if (frame_clear) begin
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bits_next;
        shreg_q   <= shreg_next;
        if (word_done) begin
          word_q     <= shreg_next;
          word_cnt_q <= sat_inc(word_cnt_q);
        end
      end
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.start      = ~cs_s;
  assign bus.frame_err  = frame_err_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_spi_word_deser.sv
// tb/tb_spi_word_deser.sv - self-checking bench for spi_word_deser
module tb_spi_word_deser;
  import spi_word_deser_pkg::*;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  spi_word_deser_if #(.WORD_W(32)) bus_a ();
  spi_word_deser_if #(.WORD_W(32)) bus_b ();

  spi_word_deser #(.WORD_W(32), .SAMPLE_EDGE(0), .MSB_FIRST(1)) dut_a (
    .sclk(sclk), .rst_n(rst_n), .bus(bus_a.slave)
  );

  spi_word_deser #(.WORD_W(32), .SAMPLE_EDGE(1), .MSB_FIRST(0)) dut_b (
    .sclk(sclk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] got_a[$];
  logic [31:0] got_b[$];
  int err_a = 0;
  int err_b = 0;
  int chg_bad = 0;
  logic [31:0] prev_word_a = '0;
  logic [31:0] prev_word_b = '0;
  logic prev_rst = 1'b0;
  logic [31:0] model_word[2];

  always @(negedge sclk) begin
    if (bus_a.word_valid === 1'b1) got_a.push_back(bus_a.word);
    if (bus_b.word_valid === 1'b1) got_b.push_back(bus_b.word);
    if (bus_a.frame_err === 1'b1) err_a++;
    if (bus_b.frame_err === 1'b1) err_b++;
    if (rst_n && prev_rst && bus_a.word_valid !== 1'b1 && bus_a.word !== prev_word_a) chg_bad++;
    if (rst_n && prev_rst && bus_b.word_valid !== 1'b1 && bus_b.word !== prev_word_b) chg_bad++;
    prev_word_a = bus_a.word;
    prev_word_b = bus_b.word;
    prev_rst    = rst_n;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge sclk);
    #2;
  endtask

  task automatic set_sck(input int d, input logic v);
    if (d == 0) bus_a.spi_sck = v; else bus_b.spi_sck = v;
  endtask

  task automatic set_cs(input int d, input logic v);
    if (d == 0) bus_a.spi_cs_n = v; else bus_b.spi_cs_n = v;
  endtask

  task automatic set_mosi(input int d, input logic v);
    if (d == 0) bus_a.spi_mosi = v; else bus_b.spi_mosi = v;
  endtask

  function automatic int got_size(input int d);
    return (d == 0) ? got_a.size() : got_b.size();
  endfunction

  function automatic logic [31:0] got_at(input int d, input int i);
    if (i >= got_size(d)) return 'x;
    return (d == 0) ? got_a[i] : got_b[i];
  endfunction

  function automatic int err_count(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  function automatic logic [31:0] out_word(input int d);
    return (d == 0) ? bus_a.word : bus_b.word;
  endfunction

  function automatic logic [15:0] out_cnt(input int d);
    return (d == 0) ? bus_a.word_cnt : bus_b.word_cnt;
  endfunction

  task automatic clear_mon();
    got_a.delete();
    got_b.delete();
    err_a = 0;
    err_b = 0;
  endtask

  // dut 0: mode-0 style, sample on rising, MSB first; dut 1: sample on falling, LSB first
  task automatic send_bit(input int d, input logic b, input int ph, input bit cs_too);
    logic idle;
    idle = (d == 0) ? 1'b0 : 1'b1;
    set_mosi(d, b);
    clk_wait(ph);
    set_sck(d, ~idle);
    if (cs_too) set_cs(d, 1'b1);
    clk_wait(ph);
    set_sck(d, idle);
  endtask

  task automatic run_frame(input int d, input logic [31:0] words[$], input int partial,
                           input logic [31:0] pbits, input int ph, input bit coincide);
    logic [31:0] w;
    int idx;
    bit last;
    set_cs(d, 1'b0);
    clk_wait(4);
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      for (int i = 0; i < 32; i++) begin
        idx  = (d == 0) ? 31 - i : i;
        last = coincide && (k == words.size() - 1) && (i == 31);
        send_bit(d, w[idx], ph, last);
      end
    end
    for (int i = 0; i < partial; i++) begin
      idx = (d == 0) ? 31 - i : i;
      send_bit(d, pbits[idx], ph, 1'b0);
    end
    if (!coincide) begin
      clk_wait(ph);
      set_cs(d, 1'b1);
    end
    clk_wait(10);
  endtask

  task automatic test_reset();
    bus_a.spi_sck = 1'b0; bus_a.spi_cs_n = 1'b1; bus_a.spi_mosi = 1'b0;
    bus_b.spi_sck = 1'b1; bus_b.spi_cs_n = 1'b1; bus_b.spi_mosi = 1'b0;
    rst_n = 1'b0;
    clk_wait(3);
    @(negedge sclk);
    total++; if (bus_a.word !== 32'h0) begin bad++; $display("FAIL reset_word got=%h want=%h", bus_a.word, 32'h0); end
    total++; if (bus_a.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus_a.word_valid); end
    total++; if (bus_a.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus_a.start); end
    total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus_a.frame_err); end
    total++; if (bus_a.word_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", bus_a.word_cnt); end
    total++; if (bus_b.start !== 1'b0) begin bad++; $display("FAIL reset_start_b got=%b want=0", bus_b.start); end
    clk_wait(1);
    rst_n = 1'b1;
    clk_wait(4);
    model_word[0] = 32'h0;
    model_word[1] = 32'h0;
  endtask

  task automatic test_start();
    clear_mon();
    set_cs(0, 1'b0);
    clk_wait(4);
    @(negedge sclk);
    total++; if (bus_a.start !== 1'b1) begin bad++; $display("FAIL start_high got=%b want=1", bus_a.start); end
    clk_wait(1);
    set_cs(0, 1'b1);
    clk_wait(6);
    total++; if (bus_a.start !== 1'b0) begin bad++; $display("FAIL start_low got=%b want=0", bus_a.start); end
    total++; if (err_a !== 0) begin bad++; $display("FAIL empty_frame_err got=%0d want=0", err_a); end
  endtask

  task automatic test_single();
    logic [31:0] ws[$];
    clear_mon();
    ws = '{32'hA5A50F0F};
    run_frame(0, ws, 0, 32'h0, 3, 1'b0);
    model_word[0] = 32'hA5A50F0F;
    total++; if (got_size(0) !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_size(0)); end
    total++; if (got_at(0, 0) !== 32'hA5A50F0F) begin bad++; $display("FAIL single_pulse_word got=%h want=a5a50f0f", got_at(0, 0)); end
    total++; if (bus_a.word !== 32'hA5A50F0F) begin bad++; $display("FAIL single_word got=%h want=a5a50f0f", bus_a.word); end
    total++; if (bus_a.word_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", bus_a.word_cnt); end
    total++; if (err_a !== 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", err_a); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws[$];
    clear_mon();
    ws = '{32'h00000003, 32'hFFFFFFFF};
    run_frame(0, ws, 0, 32'h0, 3, 1'b0);
    model_word[0] = 32'hFFFFFFFF;
    total++; if (got_size(0) !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got_size(0)); end
    total++; if (got_at(0, 0) !== 32'h00000003) begin bad++; $display("FAIL b2b_first got=%h want=00000003", got_at(0, 0)); end
    total++; if (got_at(0, 1) !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_second got=%h want=ffffffff", got_at(0, 1)); end
    total++; if (bus_a.word_cnt !== 16'd2) begin bad++; $display("FAIL b2b_cnt got=%0d want=2", bus_a.word_cnt); end
    total++; if (err_a !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d want=0", err_a); end
  endtask

  task automatic test_partial();
    logic [31:0] ws[$];
    clear_mon();
    ws = {};
    run_frame(0, ws, 20, $urandom, 3, 1'b0);
    total++; if (err_a !== 1) begin bad++; $display("FAIL partial_ferr got=%0d want=1", err_a); end
    total++; if (got_size(0) !== 0) begin bad++; $display("FAIL partial_valid got=%0d want=0", got_size(0)); end
    total++; if (bus_a.word !== model_word[0]) begin bad++; $display("FAIL partial_word got=%h want=%h", bus_a.word, model_word[0]); end
    total++; if (bus_a.word_cnt !== 16'd0) begin bad++; $display("FAIL partial_cnt got=%0d want=0", bus_a.word_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ws[$];
    logic [31:0] junk;
    clear_mon();
    junk = $urandom;
    set_cs(0, 1'b0);
    clk_wait(4);
    for (int i = 0; i < 10; i++) send_bit(0, junk[31 - i], 3, 1'b0);
    clk_wait(1);
    rst_n = 1'b0;
    clk_wait(1);
    rst_n = 1'b1;
    model_word[0] = 32'h0;
    model_word[1] = 32'h0;
    clk_wait(2);
    set_cs(0, 1'b1);
    clk_wait(8);
    total++; if (bus_a.word !== 32'h0) begin bad++; $display("FAIL rstmid_cleared got=%h want=0", bus_a.word); end
    ws = '{32'h12345678};
    run_frame(0, ws, 0, 32'h0, 3, 1'b0);
    model_word[0] = 32'h12345678;
    total++; if (bus_a.word !== 32'h12345678) begin bad++; $display("FAIL rstmid_word got=%h want=12345678", bus_a.word); end
    total++; if (got_size(0) !== 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", got_size(0)); end
    total++; if (err_a !== 0) begin bad++; $display("FAIL rstmid_ferr got=%0d want=0", err_a); end
  endtask

  task automatic test_lsb_falling();
    logic [31:0] ws[$];
    clear_mon();
    ws = '{32'h00000001};
    run_frame(1, ws, 0, 32'h0, 3, 1'b0);
    model_word[1] = 32'h00000001;
    total++; if (bus_b.word !== 32'h00000001) begin bad++; $display("FAIL lsbfall_word got=%h want=00000001", bus_b.word); end
    total++; if (got_size(1) !== 1) begin bad++; $display("FAIL lsbfall_count got=%0d want=1", got_size(1)); end
    total++; if (err_b !== 0) begin bad++; $display("FAIL lsbfall_ferr got=%0d want=0", err_b); end
  endtask

  task automatic test_coincident();
    logic [31:0] ws[$];
    logic [31:0] w;
    clear_mon();
    w = $urandom;
    ws = '{w};
    run_frame(0, ws, 0, 32'h0, 4, 1'b1);
    model_word[0] = w;
    total++; if (got_size(0) !== 1) begin bad++; $display("FAIL coinc_count got=%0d want=1", got_size(0)); end
    total++; if (bus_a.word !== w) begin bad++; $display("FAIL coinc_word got=%h want=%h", bus_a.word, w); end
    total++; if (err_a !== 0) begin bad++; $display("FAIL coinc_ferr got=%0d want=0", err_a); end
  endtask

  task automatic test_random(input int d, input int nframes);
    logic [31:0] ws[$];
    int nw, partial, ph;
    for (int f = 0; f < nframes; f++) begin
      clear_mon();
      ws = {};
      nw = $urandom_range(0, 3);
      partial = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
      if (nw == 0 && partial == 0) nw = 1;
      ph = $urandom_range(3, 5);
      for (int k = 0; k < nw; k++) ws.push_back($urandom);
      run_frame(d, ws, partial, $urandom, ph, 1'b0);
      if (nw > 0) model_word[d] = ws[nw - 1];
      total++; if (got_size(d) !== nw) begin bad++; $display("FAIL rand_count dut=%0d frame=%0d got=%0d want=%0d", d, f, got_size(d), nw); end
      for (int k = 0; k < nw; k++) begin
        total++; if (got_at(d, k) !== ws[k]) begin bad++; $display("FAIL rand_word dut=%0d frame=%0d idx=%0d got=%h want=%h", d, f, k, got_at(d, k), ws[k]); end
      end
      total++; if (err_count(d) !== ((partial != 0) ? 1 : 0)) begin bad++; $display("FAIL rand_ferr dut=%0d frame=%0d got=%0d want=%0d", d, f, err_count(d), (partial != 0) ? 1 : 0); end
      total++; if (out_cnt(d) !== 16'(nw)) begin bad++; $display("FAIL rand_cnt dut=%0d frame=%0d got=%0d want=%0d", d, f, out_cnt(d), nw); end
      total++; if (out_word(d) !== model_word[d]) begin bad++; $display("FAIL rand_hold dut=%0d frame=%0d got=%h want=%h", d, f, out_word(d), model_word[d]); end
    end
  endtask

  task automatic test_word_stable();
    total++; if (chg_bad !== 0) begin bad++; $display("FAIL word_stable got=%0d want=0", chg_bad); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_single();
    test_back_to_back();
    test_partial();
    test_reset_mid();
    test_lsb_falling();
    test_coincident();
    test_random(0, 8);
    test_random(1, 5);
    test_word_stable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
